washing_machine_water_fill_controller: RTL

WASHING_MACHINE_WATER_FILL_CONTROLLER -- requirements
Module: washing_machine_water_fill_controller

---
 rtl/washing_machine_pkg.sv | 36 +++
 rtl/washing_machine_fill_timer.sv | 41 ++++
 rtl/washing_machine_water_fill_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/washing_machine_pkg.sv
// -----------------------------------------------------------------------------
// washing_machine_pkg
// Shared definitions for the washing machine control blocks: fill controller
// state encoding, fault codes, the load-size water level constants used by
// both load-size detection and the fill controller, and a level helper.
// No ports (package).
// -----------------------------------------------------------------------------
package washing_machine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } fill_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_INVALID = 2'd2
    } fault_code_t;

    // Target levels in sensor units, one per detected load size.
    localparam logic [9:0] LEVEL_SMALL  = 10'd175;
    localparam logic [9:0] LEVEL_MEDIUM = 10'd300;
    localparam logic [9:0] LEVEL_LARGE  = 10'd600;
    localparam logic [9:0] LEVEL_XLARGE = 10'd900;

    // Level subtraction clamped at empty, so a small target never wraps the
    // hysteresis threshold around to a huge value.
    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : 10'd0;
    endfunction

endpackage

// File: rtl/washing_machine_fill_timer.sv
// -----------------------------------------------------------------------------
// washing_machine_fill_timer
// Saturating cycle counter that bounds the time spent filling.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-high; count returns to 0
//   clear   - synchronous clear (held while the controller is not filling)
//   enable  - count one cycle
//   expired - high during the LIMIT-th enabled cycle since clear, and after,
//             so the controller leaves on exactly the LIMIT-th edge
// -----------------------------------------------------------------------------
module washing_machine_fill_timer #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = 16'd1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    // count holds the number of completed cycles, so the current cycle is the
    // (count+1)-th; flag it when that reaches LIMIT.
    assign expired = (LIMIT == '0) || (count >= (LIMIT - WIDTH'(1)));

endmodule

// File: rtl/washing_machine_water_fill_controller.sv
// -----------------------------------------------------------------------------
// washing_machine_water_fill_controller
// Opens the inlet valve until the water level reaches the latched target,
// waits for the level to stay there for SETTLE_CYCLES, and reports done.
// Bounded by a timeout; invalid targets and timeouts raise a fault.
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   start         - request a fill (sampled only in IDLE)
//   target_level  - requested level, latched when start is accepted
//   level_sensor  - current water level
//   abort         - return to IDLE from any state, highest priority
//   ack           - acknowledge DONE or FAULT
//   valve_open    - inlet valve drive (high only in FILL)
//   busy          - high in FILL or SETTLE
//   fill_done     - high in DONE
//   fault         - high in FAULT
//   fault_code    - 0 none, 1 timeout, 2 invalid target
// All outputs are registered decodes of the next state, so they change on the
// same edge as the state register.
// -----------------------------------------------------------------------------
module washing_machine_water_fill_controller
    import washing_machine_pkg::*;
#(
    parameter int          SETTLE_CYCLES  = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [9:0]  HYST           = 10'd8,
    parameter logic [9:0]  MAX_LEVEL      = 10'd950
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] target_level,
    input  logic [9:0] level_sensor,
    input  logic       abort,
    input  logic       ack,
    output logic       valve_open,
    output logic       busy,
    output logic       fill_done,
    output logic       fault,
    output logic [1:0] fault_code
);

    // Settle count value at which one more good sample completes the fill.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    fill_state_t state_q, state_d;
    logic [7:0]  settle_cnt, settle_d;
    logic [9:0]  target_q, target_d;
    logic [1:0]  code_d;
    logic        timer_run;
    logic        timer_expired;

    assign timer_run = (state_q == ST_FILL) || (state_q == ST_SETTLE);

    // Cleared whenever not filling, so it restarts from 0 on entry from IDLE
    // but keeps counting across SETTLE <-> FILL moves.
    washing_machine_fill_timer #(
        .WIDTH (16),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_fill_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!timer_run),
        .enable  (timer_run),
        .expired (timer_expired)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_cnt;
        target_d = target_q;
        code_d   = fault_code;

        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            settle_d = 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    settle_d = 8'd0;
                    if (start && !abort) begin
                        if (target_level > MAX_LEVEL) begin
                            state_d = ST_FAULT;
                            code_d  = FC_INVALID;
                        end else if (target_level == 10'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            target_d = target_level;
                            state_d  = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (timer_expired) begin
                        state_d = ST_FAULT;
                        code_d  = FC_TIMEOUT;
                    end else if (level_sensor >= target_q) begin
                        state_d  = ST_SETTLE;
                        settle_d = 8'd1;
                    end
                end
                ST_SETTLE: begin
                    // Timeout is tested first so it wins over settle completion.
                    if (timer_expired) begin
                        state_d = ST_FAULT;
                        code_d  = FC_TIMEOUT;
                    end else if (level_sensor >= target_q) begin
                        if (settle_cnt >= SETTLE_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            settle_d = settle_cnt + 8'd1;
                        end
                    end else if (level_sensor < sat_sub(target_q, HYST)) begin
                        state_d  = ST_FILL;
                        settle_d = 8'd0;
                    end
                    // Inside the hysteresis band: hold state and count.
                end
                ST_DONE: begin
                    if (ack) state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    if (ack) state_d = ST_IDLE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    settle_d = 8'd0;
                end
            endcase
        end

        // fault_code is only meaningful alongside fault.
        if (state_d != ST_FAULT) code_d = FC_NONE;
    end

    // NOTE: reset clears the latched target and counters too, so a fill
    // interrupted by reset leaves no stale context behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            settle_cnt <= 8'd0;
            target_q   <= 10'd0;
            valve_open <= 1'b0;
            busy       <= 1'b0;
            fill_done  <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state_q    <= state_d;
            settle_cnt <= settle_d;
            target_q   <= target_d;
            valve_open <= (state_d == ST_FILL);
            busy       <= (state_d == ST_FILL) || (state_d == ST_SETTLE);
            fill_done  <= (state_d == ST_DONE);
            fault      <= (state_d == ST_FAULT);
            fault_code <= code_d;
        end
    end

endmodule
